ram_dp_be_clr: RTL and testbench

Parametrised simple-dual-port RAM: one synchronous write port with byte-lane enables and one read port with selectable asynchronous or registered read. It adds a hardware clear engine that zeroes every entry after reset or on request, plus configurable read-during-write (collision) behaviour. It is the general-purpose storage element for buffers and register files in the design, and succeeds the fixed single-mode dual-port RAM.

---
 rtl/ram_dp_be_clr.sv | 106 ++++++++++
 tb/tb_ram_dp_be_clr.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_be_clr.sv
// Simple-dual-port RAM with byte-lane writes, optional registered read,
// selectable collision bypass and a hardware clear engine that zeroes the array.
module ram_dp_be_clr #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned LANE   = 8,
    parameter int unsigned RD_REG = 0,
    parameter int unsigned BYPASS = 1,
    parameter int unsigned AW     = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    we,
    input  logic [WIDTH/LANE-1:0]   be,
    input  logic [AW-1:0]           addr_wr,
    input  logic [WIDTH-1:0]        data_wr,
    input  logic [AW-1:0]           addr_rd,
    output logic [WIDTH-1:0]        data_rd,
    output logic                    busy,
    output logic                    wr_drop
);

    localparam int unsigned NB = WIDTH / LANE;

    typedef enum logic {StClear, StIdle} state_e;

    state_e           state_q;
    logic [AW-1:0]    clr_ptr_q;
    logic [WIDTH-1:0] mem [DEPTH];

    logic             wr_in_range;
    logic             rd_in_range;
    logic             wr_acc;
    logic             collide;
    logic [WIDTH-1:0] stored;
    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] rd_word;

    assign wr_in_range = 32'(addr_wr) < DEPTH;
    assign rd_in_range = 32'(addr_rd) < DEPTH;
    assign wr_acc      = ~busy & we & wr_in_range;
    assign collide     = wr_acc & (addr_wr == addr_rd);
    assign stored      = rd_in_range ? mem[addr_rd] : '0;

    always_comb begin
        merged = stored;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) merged[i*LANE +: LANE] = data_wr[i*LANE +: LANE];
        end
    end

    always_comb begin
        rd_word = '0;
        if (!busy && rd_in_range) begin
            rd_word = (BYPASS != 0 && collide) ? merged : stored;
        end
    end

    // Clear engine: busy is a registered copy of "state is StClear".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StClear;
            clr_ptr_q <= '0;
            busy      <= 1'b1;
            wr_drop   <= 1'b0;
        end else begin
            wr_drop <= we & (busy | ~wr_in_range);
            if (clr) begin
                state_q   <= StClear;
                clr_ptr_q <= '0;
                busy      <= 1'b1;
            end else if (state_q == StClear) begin
                if (clr_ptr_q == AW'(DEPTH - 1)) begin
                    state_q   <= StIdle;
                    clr_ptr_q <= '0;
                    busy      <= 1'b0;
                end else begin
                    clr_ptr_q <= clr_ptr_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == StClear) begin
            mem[clr_ptr_q] <= '0;
        end else if (wr_acc) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem[addr_wr][i*LANE +: LANE] <= data_wr[i*LANE +: LANE];
            end
        end
    end

    if (RD_REG != 0) begin : g_rd_reg
        logic [WIDTH-1:0] rd_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) rd_q <= '0;
            else     rd_q <= rd_word;
        end
        assign data_rd = rd_q;
    end else begin : g_rd_async
        assign data_rd = rd_word;
    end

endmodule

// File: tb/tb_ram_dp_be_clr.sv
// Bench for ram_dp_be_clr: four configurations share one stimulus stream and are
// checked against an array-based reference model with a clear countdown.
module tb_ram_dp_be_clr;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic        we  = 1'b0;
    logic [3:0]  be  = 4'h0;
    logic [4:0]  addr_wr = 5'd0;
    logic [4:0]  addr_rd = 5'd0;
    logic [31:0] data_wr = 32'h0;

    logic [31:0] rd0, rd1, rd2, rd3;
    logic        bz0, bz1, bz2, bz3;
    logic        dr0, dr1, dr2, dr3;

    logic [31:0] mem_m [N][17];
    int          left_m [N];
    logic        drop_m [N];
    logic [31:0] rdq_m  [N];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // 0: D16 async write-first, 1: D16 registered read-first,
    // 2: D17 async read-first,  3: D17 registered write-first
    ram_dp_be_clr #(.WIDTH(32), .DEPTH(16), .LANE(8), .RD_REG(0), .BYPASS(1)) u_d0 (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .be(be), .addr_wr(addr_wr[3:0]),
        .data_wr(data_wr), .addr_rd(addr_rd[3:0]), .data_rd(rd0), .busy(bz0), .wr_drop(dr0));
    ram_dp_be_clr #(.WIDTH(32), .DEPTH(16), .LANE(8), .RD_REG(1), .BYPASS(0)) u_d1 (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .be(be), .addr_wr(addr_wr[3:0]),
        .data_wr(data_wr), .addr_rd(addr_rd[3:0]), .data_rd(rd1), .busy(bz1), .wr_drop(dr1));
    ram_dp_be_clr #(.WIDTH(32), .DEPTH(17), .LANE(8), .RD_REG(0), .BYPASS(0)) u_d2 (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .be(be), .addr_wr(addr_wr),
        .data_wr(data_wr), .addr_rd(addr_rd), .data_rd(rd2), .busy(bz2), .wr_drop(dr2));
    ram_dp_be_clr #(.WIDTH(32), .DEPTH(17), .LANE(8), .RD_REG(1), .BYPASS(1)) u_d3 (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .be(be), .addr_wr(addr_wr),
        .data_wr(data_wr), .addr_rd(addr_rd), .data_rd(rd3), .busy(bz3), .wr_drop(dr3));

    function automatic int dep(int k);
        return (k < 2) ? 16 : 17;
    endfunction

    function automatic bit rdreg(int k);
        return (k == 1 || k == 3);
    endfunction

    function automatic bit byp(int k);
        return (k == 0 || k == 3);
    endfunction

    function automatic logic [31:0] rd_of(int k);
        case (k)
            0: return rd0;
            1: return rd1;
            2: return rd2;
            default: return rd3;
        endcase
    endfunction

    function automatic logic bz_of(int k);
        case (k)
            0: return bz0;
            1: return bz1;
            2: return bz2;
            default: return bz3;
        endcase
    endfunction

    function automatic logic dr_of(int k);
        case (k)
            0: return dr0;
            1: return dr1;
            2: return dr2;
            default: return dr3;
        endcase
    endfunction

    // 16-deep instances see only the low 4 address bits
    function automatic int wa_of(int k);
        return (dep(k) == 16) ? int'(addr_wr[3:0]) : int'(addr_wr);
    endfunction

    function automatic int ra_of(int k);
        return (dep(k) == 16) ? int'(addr_rd[3:0]) : int'(addr_rd);
    endfunction

    function automatic bit acc_m(int k);
        return left_m[k] == 0 && we && wa_of(k) < dep(k);
    endfunction

    function automatic logic [31:0] rd_now(int k);
        logic [31:0] w;
        int ra;
        ra = ra_of(k);
        if (left_m[k] > 0 || ra >= dep(k)) return 32'h0;
        w = mem_m[k][ra];
        if (byp(k) && acc_m(k) && wa_of(k) == ra) begin
            for (int i = 0; i < 4; i++) if (be[i]) w[i*8 +: 8] = data_wr[i*8 +: 8];
        end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            left_m[k] = dep(k);
            drop_m[k] = 1'b0;
            rdq_m[k]  = 32'h0;
            for (int a = 0; a < 17; a++) mem_m[k][a] = 32'h0;
        end
    endtask

    // One clock: pre-edge async read check, model update, post-edge checks.
    task automatic cycle();
        logic [31:0] nrdq;
        logic        ndrop;
        #1;
        for (int k = 0; k < N; k++) begin
            if (!rdreg(k)) chk($sformatf("pre_rd%0d", k), rd_of(k), rd_now(k));
        end
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                nrdq  = rd_now(k);
                ndrop = we && (left_m[k] > 0 || wa_of(k) >= dep(k));
                if (acc_m(k)) begin
                    for (int i = 0; i < 4; i++)
                        if (be[i]) mem_m[k][wa_of(k)][i*8 +: 8] = data_wr[i*8 +: 8];
                end
                if (clr) begin
                    left_m[k] = dep(k);
                    for (int a = 0; a < 17; a++) mem_m[k][a] = 32'h0;
                end else if (left_m[k] > 0) begin
                    left_m[k]--;
                end
                rdq_m[k]  = nrdq;
                drop_m[k] = ndrop;
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            chk($sformatf("busy%0d", k), 32'(bz_of(k)), 32'(left_m[k] > 0));
            chk($sformatf("drop%0d", k), 32'(dr_of(k)), 32'(drop_m[k]));
            chk($sformatf("post_rd%0d", k), rd_of(k), rdreg(k) ? rdq_m[k] : rd_now(k));
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < N; k++) begin
            chk($sformatf("rst_busy%0d", k), 32'(bz_of(k)), 32'h1);
            chk($sformatf("rst_drop%0d", k), 32'(dr_of(k)), 32'h0);
            chk($sformatf("rst_rd%0d", k), rd_of(k), 32'h0);
        end
        @(negedge clk);
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] b);
        we = 1'b1; addr_wr = a; data_wr = d; be = b;
        cycle();
        we = 1'b0;
    endtask

    // Counts cycles in which busy is high, sampled just before each edge.
    task automatic count_busy(input int clr_at, output int n [N]);
        for (int k = 0; k < N; k++) n[k] = 0;
        for (int i = 0; i < 30; i++) begin
            for (int k = 0; k < N; k++) if (bz_of(k)) n[k]++;
            clr = (i == 0 && clr_at >= 0) || (i == clr_at);
            cycle();
            clr = 1'b0;
        end
    endtask

    initial begin
        int n [N];

        // Power-up reset and clear length
        do_reset();
        count_busy(-1, n);
        for (int k = 0; k < N; k++) chk($sformatf("rst_len%0d", k), n[k], dep(k));

        // Preload, then reset must wipe it
        wr(5'd5, 32'h0000_00A5, 4'hF);
        addr_rd = 5'd5;
        #1 chk("preload", rd0, 32'h0000_00A5);
        @(negedge clk);
        do_reset();
        count_busy(-1, n);
        for (int k = 0; k < N; k++) chk($sformatf("rst2_len%0d", k), n[k], dep(k));
        addr_rd = 5'd5;
        #1 chk("wiped5", rd0, 32'h0);
        @(negedge clk);
        for (int a = 0; a < 17; a++) begin
            addr_rd = 5'(a);
            cycle();
        end

        // Byte lanes
        wr(5'd7, 32'h1122_3344, 4'hF);
        wr(5'd7, 32'hAABB_CCDD, 4'b0101);
        addr_rd = 5'd7;
        #1 chk("lanes0", rd0, 32'h11BB_33DD);
        chk("lanes2", rd2, 32'h11BB_33DD);
        @(negedge clk);

        // Collision at address 3
        wr(5'd3, 32'h0000_0010, 4'hF);
        addr_rd = 5'd3; addr_wr = 5'd3; data_wr = 32'h0000_007E; be = 4'hF; we = 1'b1;
        #1 chk("coll_wf", rd0, 32'h0000_007E);
        chk("coll_rf_pre", rd2, 32'h0000_0010);
        cycle();
        chk("coll_rf_post", rd2, 32'h0000_007E);
        we = 1'b0;

        // Registered read latency
        wr(5'd2, 32'h0000_0042, 4'hF);
        addr_rd = 5'd4;
        cycle();
        addr_rd = 5'd2;
        #1 chk("rdreg_before", rd1, 32'h0);
        cycle();
        chk("rdreg_after", rd1, 32'h0000_0042);

        // Drops: during busy, then out-of-range address on 17-deep parts
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        wr(5'd6, 32'h0000_00FF, 4'hF);
        chk("drop_busy", 32'(dr0), 32'h1);
        cycle();
        chk("drop_busy_end", 32'(dr0), 32'h0);
        for (int i = 0; i < 16; i++) cycle();
        addr_rd = 5'd6;
        #1 chk("drop_busy_nowrite", rd0, 32'h0);
        @(negedge clk);
        wr(5'd17, 32'hDEAD_BEEF, 4'hF);
        chk("drop_range", 32'(dr2), 32'h1);
        cycle();
        chk("drop_range_end", 32'(dr2), 32'h0);

        // clr in IDLE, then again five cycles into the clear
        wr(5'd9, 32'h5555_AAAA, 4'hF);
        count_busy(5, n);
        for (int k = 0; k < N; k++) chk($sformatf("clr_len%0d", k), n[k], dep(k) + 5);
        for (int a = 0; a < 17; a++) begin
            addr_rd = 5'(a);
            cycle();
        end

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            we      = 1'($urandom_range(0, 1));
            be      = 4'($urandom);
            addr_wr = 5'($urandom_range(0, 18));
            addr_rd = ($urandom_range(0, 3) == 0) ? addr_wr : 5'($urandom_range(0, 18));
            data_wr = $urandom;
            clr     = ($urandom_range(0, 59) == 0);
            cycle();
        end
        clr = 1'b0;
        we  = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
